// File: rtl/mem_defs.sv
// Shared definitions for the main memory responder: FSM state encoding,
// default line width and the byte-offset width inside one line.
package mem_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam int LINE_WIDTH  = 128;
  localparam int OFFSET_BITS = 4;

endpackage

// File: rtl/mem_line_array.sv
// Line storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset so data survives a controller reset.
module mem_line_array #(
  parameter int LINE_WIDTH = 128,
  parameter int MEM_LINES  = 1024,
  parameter int IDX_W      = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [LINE_WIDTH-1:0] wr_line,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [LINE_WIDTH-1:0] rd_line
);

  logic [LINE_WIDTH-1:0] lines [MEM_LINES];

  // Commit a full line on the write-enable edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      lines[wr_idx] <= wr_line;
    end
  end

  assign rd_line = lines[rd_idx];

endmodule

// File: rtl/main_memory_responder.sv
// Main memory responder: accepts one line read or write-back per request,
// waits a fixed latency, then pulses main_mem_ack for one cycle.
//
// state | meaning
// IDLE  | waiting for mem_req; request fields captured on leaving
// WAIT  | latency counter running down to zero
// RESP  | ack cycle; read data valid, write committed on the exit edge
module main_memory_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int MEM_LINES  = 1024,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_addr,
  input  logic [LINE_WIDTH-1:0] mem_wdata,
  output logic                  main_mem_ack,
  output logic [LINE_WIDTH-1:0] mem_rdata,
  output logic                  mem_busy
);

  import mem_defs::*;

  localparam int         IDX_W    = $clog2(MEM_LINES);
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  mem_state_t            state;
  mem_state_t            state_nxt;
  logic [3:0]            lat_cnt;
  logic                  cap_we;
  logic [IDX_W-1:0]      cap_idx;
  logic [LINE_WIDTH-1:0] cap_wdata;
  logic [LINE_WIDTH-1:0] rd_line;
  logic                  arr_we;
  logic                  unused_addr;

  // Offset bits and bits above the line index alias freely and are never used.
  assign unused_addr = ^mem_addr;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a request seen in RESP is ignored until IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_req) state_nxt = WAIT;
      WAIT:    if (lat_cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the state.
  always_comb begin
    main_mem_ack = (state == RESP);
    mem_busy     = (state != IDLE);
  end

  // Capture the request in IDLE and run the latency counter in WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_cnt   <= 4'd0;
      cap_we    <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            lat_cnt   <= LAT_LOAD;
            cap_we    <= mem_we;
            cap_idx   <= mem_addr[IDX_W+OFFSET_BITS-1:OFFSET_BITS];
            cap_wdata <= mem_wdata;
          end
        end
        WAIT: begin
          if (lat_cnt != 4'd0) begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        default: begin
          lat_cnt <= lat_cnt;
        end
      endcase
    end
  end

  // Load read data on the edge entering RESP; hold it otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rdata <= '0;
    end else if (state == WAIT && lat_cnt == 4'd0 && !cap_we) begin
      mem_rdata <= rd_line;
    end
  end

  // A write commits only on a clean RESP exit; a reset edge aborts it.
  assign arr_we = (state == RESP) && cap_we && !reset;

  mem_line_array #(
    .LINE_WIDTH (LINE_WIDTH),
    .MEM_LINES  (MEM_LINES),
    .IDX_W      (IDX_W)
  ) u_lines (
    .clk     (clk),
    .wr_en   (arr_we),
    .wr_idx  (cap_idx),
    .wr_line (cap_wdata),
    .rd_idx  (cap_idx),
    .rd_line (rd_line)
  );

endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench for main_memory_responder: a LATENCY=4 instance and a
// LATENCY=1 instance, checked against a line-array model with transaction timing.
module tb_main_memory_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic         req   [2];
  logic         we    [2];
  logic [31:0]  addr  [2];
  logic [127:0] wdata [2];
  logic         ack   [2];
  logic         busy  [2];
  logic [127:0] rdata [2];

  int           lat [2] = '{4, 1};
  logic [127:0] model_mem [2][1024];
  bit           valid     [2][1024];
  logic [127:0] last_rd   [2];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ack_cyc  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  main_memory_responder dut0 (
    .clk          (clk),
    .reset        (reset),
    .mem_req      (req[0]),
    .mem_we       (we[0]),
    .mem_addr     (addr[0]),
    .mem_wdata    (wdata[0]),
    .main_mem_ack (ack[0]),
    .mem_rdata    (rdata[0]),
    .mem_busy     (busy[0])
  );

  main_memory_responder #(.LATENCY(1)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .mem_req      (req[1]),
    .mem_we       (we[1]),
    .mem_addr     (addr[1]),
    .mem_wdata    (wdata[1]),
    .main_mem_ack (ack[1]),
    .mem_rdata    (rdata[1]),
    .mem_busy     (busy[1])
  );

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One complete transaction; starts at #1 after an edge with the DUT idle,
  // or in the RESP cycle of the previous transaction when after_resp is set.
  task automatic run_txn(input int w, input bit t_we, input logic [31:0] a,
                         input logic [127:0] d, input bit hold, input bit after_resp);
    int           idx;
    logic [127:0] exp_line;
    idx = int'(a[13:4]);
    req[w] = 1'b1; we[w] = t_we; addr[w] = a; wdata[w] = d;
    if (after_resp) begin
      @(posedge clk); #1;
      check("b2b_idle_between", {127'd0, busy[w]}, 128'd0);
    end
    @(posedge clk); #1;
    check("capture_busy", {127'd0, busy[w]}, 128'd1);
    check("capture_no_ack", {127'd0, ack[w]}, 128'd0);
    // Scramble every request field after capture; the transaction must not notice.
    we[w]    = 1'($urandom_range(0, 1));
    addr[w]  = $urandom;
    wdata[w] = rand128();
    exp_line = t_we ? last_rd[w] : model_mem[w][idx];
    for (int k = 1; k <= lat[w]; k++) begin
      @(posedge clk); #1;
      check("ack_timing", {127'd0, ack[w]}, (k == lat[w]) ? 128'd1 : 128'd0);
      check("busy_in_txn", {127'd0, busy[w]}, 128'd1);
      if (k < lat[w]) check("rdata_hold_wait", rdata[w], last_rd[w]);
    end
    ack_cyc = cyc;
    if (t_we) begin
      check("rdata_unchanged_by_write", rdata[w], exp_line);
      model_mem[w][idx] = d;
      valid[w][idx]     = 1'b1;
    end else begin
      check("read_data", rdata[w], exp_line);
      last_rd[w] = exp_line;
    end
    if (!hold) begin
      req[w] = 1'b0;
      @(posedge clk); #1;
      check("idle_busy", {127'd0, busy[w]}, 128'd0);
      check("idle_no_ack", {127'd0, ack[w]}, 128'd0);
      check("idle_rdata_hold", rdata[w], last_rd[w]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int           first_ack;
    logic [127:0] line_a, line_b, line_d1, line_c;
    logic [31:0]  a;
    int           idx;
    bit           t_we, hold, prev_hold;

    reset = 1'b1;
    for (int w = 0; w < 2; w++) begin
      req[w] = 1'b0; we[w] = 1'b0; addr[w] = '0; wdata[w] = '0; last_rd[w] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      check("reset_busy", {127'd0, busy[w]}, 128'd0);
      check("reset_ack", {127'd0, ack[w]}, 128'd0);
      check("reset_rdata", rdata[w], 128'd0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    // Write then read the same line.
    line_a = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    run_txn(0, 1'b1, 32'h0000_1230, line_a, 1'b0, 1'b0);
    run_txn(0, 1'b0, 32'h0000_1230, 128'd0, 1'b0, 1'b0);

    // Second line, then back-to-back reads with mem_req held across the ack.
    line_b = rand128();
    run_txn(0, 1'b1, 32'h0000_2000, line_b, 1'b0, 1'b0);
    run_txn(0, 1'b0, 32'h0000_1230, 128'd0, 1'b1, 1'b0);
    first_ack = ack_cyc;
    run_txn(0, 1'b0, 32'h0000_2000, 128'd0, 1'b0, 1'b1);
    check("b2b_ack_spacing", 128'(ack_cyc - first_ack), 128'(lat[0] + 2));

    // Reset in WAIT of a write to index 5 aborts it; storage keeps prior data.
    line_d1 = rand128();
    run_txn(0, 1'b1, 32'h0000_0050, line_d1, 1'b0, 1'b0);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h0000_0050; wdata[0] = rand128();
    @(posedge clk); #1;
    check("abort_capture_busy", {127'd0, busy[0]}, 128'd1);
    @(posedge clk); #1;
    check("abort_wait_no_ack", {127'd0, ack[0]}, 128'd0);
    reset = 1'b1; req[0] = 1'b0;
    @(posedge clk); #1;
    check("abort_reset_busy", {127'd0, busy[0]}, 128'd0);
    check("abort_reset_rdata", rdata[0], 128'd0);
    reset = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("abort_no_ack", {127'd0, ack[0]}, 128'd0);
    end
    run_txn(0, 1'b0, 32'h0000_0050, 128'd0, 1'b0, 1'b0);

    // LATENCY=1 instance: aliasing through ignored high address bits.
    line_c = rand128();
    run_txn(1, 1'b1, 32'h0000_0010, line_c, 1'b0, 1'b0);
    run_txn(1, 1'b0, 32'h0001_0010, 128'd0, 1'b1, 1'b0);
    first_ack = ack_cyc;
    run_txn(1, 1'b0, 32'hFFFF_C010, 128'd0, 1'b0, 1'b1);
    check("b2b_ack_spacing_lat1", 128'(ack_cyc - first_ack), 128'(lat[1] + 2));

    // Randomized traffic on a small index range so lines get revisited.
    for (int w = 0; w < 2; w++) begin
      prev_hold = 1'b0;
      for (int n = 0; n < 30; n++) begin
        idx  = $urandom_range(0, 15);
        t_we = 1'($urandom_range(0, 1));
        if (!valid[w][idx]) t_we = 1'b1;
        a = $urandom;
        a[13:4] = 10'(idx);
        hold = (n != 29) && ($urandom_range(0, 1) == 1);
        run_txn(w, t_we, a, rand128(), hold, prev_hold);
        prev_hold = hold;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/main_memory_responder.md
MAIN_MEMORY_RESPONDER -- requirements
Module: main_memory_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32; width of the request address.
REQ-002 Parameter LINE_WIDTH, default 128; width of one cache line transferred per transaction.
REQ-003 Parameter MEM_LINES, default 1024; number of line-sized storage entries (power of two).
REQ-004 Parameter LATENCY, default 4, legal range 1..15; cycles from request capture to ack.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 mem_req  input  1  level request from the cache controller; held until main_mem_ack is seen.
REQ-009 mem_we  input  1  1 = line write-back, 0 = line refill read; valid while mem_req=1.
REQ-010 mem_addr  input  DATA_WIDTH  byte address; bits [3:0] ignored (line-aligned).
REQ-011 mem_wdata  input  LINE_WIDTH  write-back line; valid while mem_req=1 and mem_we=1.
REQ-012 main_mem_ack  output  1  one-cycle completion pulse.
REQ-013 mem_rdata  output  LINE_WIDTH  refill line; valid in the ack cycle of a read.
REQ-014 mem_busy  output  1  high from request capture through the ack cycle.

Function
REQ-015 The state machine SHALL have states IDLE, WAIT, and RESP.
REQ-016 In IDLE with mem_req=1, the block SHALL capture mem_we, the line index, and mem_wdata, load the latency counter with LATENCY-1, and enter WAIT.
REQ-017 In WAIT, the counter SHALL decrement each cycle; at counter==0 the next state SHALL be RESP.
REQ-018 main_mem_ack SHALL be high exactly in RESP, for exactly one cycle; the ack cycle is the LATENCY-th cycle after the capturing edge.
REQ-019 Line index = mem_addr[log2(MEM_LINES)+3:4]; higher address bits SHALL be ignored (aliasing, no error).
REQ-020 Read: in RESP, mem_rdata SHALL equal the stored line at the captured index; outside read RESP cycles, mem_rdata SHALL hold its last value.
REQ-021 Write: the captured line SHALL be committed to storage on the clock edge that leaves RESP; mem_rdata is unchanged by writes.
REQ-022 Input changes after capture (address, data, mem_we) SHALL NOT affect the transaction in progress.
REQ-023 RESP SHALL always return to IDLE; mem_req sampled in the RESP cycle SHALL be ignored.
REQ-024 A request still high in the first IDLE cycle after RESP SHALL start a new transaction.
REQ-025 A read following a write to the same line SHALL return the written data.
REQ-026 mem_busy SHALL equal (state != IDLE).

Reset
REQ-027 On reset: state=IDLE, counter=0, main_mem_ack=0, mem_busy=0, mem_rdata=0.
REQ-028 Reset SHALL NOT clear storage contents.
REQ-029 Reset in WAIT or RESP SHALL abort the transaction with no ack; a write not yet past its RESP exit edge SHALL NOT be committed.

Structure
REQ-030 Shared package mem_defs SHALL hold the state enum (mem_state_t), LINE_WIDTH, and OFFSET_BITS=4.
REQ-031 Line storage SHALL be a sub-module mem_line_array (1 write port, 1 read port, synchronous write).
REQ-032 The FSM, counter, and capture registers SHALL reside in main_memory_responder.

Verification
REQ-033 Write, then read: write 0x0123..CDEF at 0x0000_1230, then read the same address -> read ack exactly 4 cycles after capture; mem_rdata = written line.
REQ-034 Input change after capture: hold mem_req=1 and change mem_addr 1 cycle after capture -> the originally captured line is returned; the new address is ignored.
REQ-035 Back-to-back requests: keep mem_req high across ack -> second capture in the first IDLE cycle after RESP; acks are LATENCY+2 cycles apart.
REQ-036 Reset mid-write: assert reset in WAIT of a write to index 5 -> no ack; a later read of index 5 returns the prior contents.
REQ-037 Aliasing: with LATENCY=1 and MEM_LINES=1024, write at 0x0000_0010, then read at 0x0001_0010 -> ack on the cycle after capture; aliased read returns the written line.
